// File: rtl/uart_rx_if.sv
// Byte-side and line-side signals of the 16x-oversampled UART receiver.
// The master drives enable, tick and line; the slave (uart_rx) returns the recovered bytes.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 en;
  logic                 baud_tick;
  logic                 Rx;
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 frame_err;

  modport master (
    output en, baud_tick, Rx,
    input  data_out, data_valid, frame_err
  );

  modport slave (
    input  en, baud_tick, Rx,
    output data_out, data_valid, frame_err
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 1 start, DATA_BITS data (MSB first), 1 stop, oversampled by baud_tick.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority bit decisions around mid-bit.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic     clk,
  input  logic     arst_n,
  uart_rx_if.slave bus
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] DECIDE = CW'(OVERSAMPLE / 2);
`else
  localparam logic [CW-1:0] DECIDE = CW'(OVERSAMPLE / 2 - 1);
`endif
  localparam logic [CW-1:0] LAST_TICK = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic                 rx_meta_q, rx_s_q;
  logic                 bit_dec;

  // NOTE: the synchronizer resets to 1 so an idle line never looks like a start bit
  // coming out of reset.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.Rx;
      rx_s_q    <= rx_meta_q;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] samp_q, samp_d;

  always_comb begin
    samp_d = samp_q;
    if (bus.baud_tick && tick_q == DECIDE - CW'(2)) samp_d[0] = rx_s_q;
    if (bus.baud_tick && tick_q == DECIDE - CW'(1)) samp_d[1] = rx_s_q;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) samp_q <= 2'b11;
    else         samp_q <= samp_d;
  end

  assign bit_dec = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
`else
  assign bit_dec = rx_s_q;
`endif

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;

    if (!bus.en) begin
      state_d = IDLE;
      tick_d  = '0;
      bit_d   = '0;
      shift_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          tick_d = '0;
          bit_d  = '0;
          if (bus.baud_tick && !rx_s_q) state_d = START;
        end
        START: begin
          if (bus.baud_tick) tick_d = tick_q + CW'(1);
          if (bus.baud_tick && tick_q == DECIDE && bit_dec) begin
            state_d = IDLE;
            tick_d  = '0;
          end else if (bus.baud_tick && tick_q == LAST_TICK) begin
            state_d = DATA;
            bit_d   = '0;
          end
        end
        DATA: begin
          if (bus.baud_tick) tick_d = tick_q + CW'(1);
          if (bus.baud_tick && tick_q == DECIDE)
            shift_d = {shift_q[DATA_BITS-2:0], bit_dec};
          if (bus.baud_tick && tick_q == LAST_TICK) begin
            if (bit_q == LAST_BIT) begin
              state_d = STOP;
              bit_d   = '0;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end
        end
        STOP: begin
          if (bus.baud_tick) tick_d = tick_q + CW'(1);
          // Leaving at the sample point lets a back-to-back start bit be seen on time.
          if (bus.baud_tick && tick_q == DECIDE) begin
            if (bit_dec) begin
              data_out_d = shift_q;
              valid_d    = 1'b1;
            end else begin
              err_d = 1'b1;
            end
            state_d = IDLE;
            tick_d  = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = valid_q;
  assign bus.frame_err  = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a tick-offset frame model checked every cycle,
// plus literal expectations after each directed frame.
module tb_uart_rx;
  localparam int OS = 16;
  localparam int DB = 8;
`ifdef UART_RX_MAJORITY_EN
  localparam int         M          = 1;
  localparam logic [7:0] GLITCH_EXP = 8'h00;
`else
  localparam int         M          = 0;
  localparam logic [7:0] GLITCH_EXP = 8'h10;
`endif

  logic clk    = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_if #(.DATA_BITS(DB)) bus ();

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  int ncmp  = 0;
  int nfail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: offsets in ticks from the start-detect tick; bit j is decided at j*OS + OS/2 (+1 majority).
  logic       exp_valid = 1'b0;
  logic       exp_err   = 1'b0;
  logic [7:0] exp_data  = 8'h00;

  initial begin : model
    int         d;
    int         off;
    int         j;
    logic [2:0] hist;
    logic [7:0] mbyte;
    logic       bitv;
    d     = -1;
    hist  = 3'b111;
    mbyte = 8'h00;
    forever begin
      @(posedge clk or negedge arst_n);
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      if (!arst_n) begin
        d        = -1;
        exp_data = 8'h00;
      end else if (!bus.en) begin
        d = -1;
      end else if (bus.baud_tick) begin
        hist = {hist[1:0], bus.Rx};
        if (d < 0) begin
          if (!bus.Rx) d = 0;
        end else begin
          d++;
          off = d - (OS / 2 + M);
          if (off >= 0 && off % OS == 0) begin
            j    = off / OS;
            bitv = (M == 1) ? ((hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]))
                            : bus.Rx;
            if (j == 0) begin
              if (bitv) d = -1;
            end else if (j <= DB) begin
              mbyte = {mbyte[6:0], bitv};
            end else begin
              if (bitv) begin
                exp_valid = 1'b1;
                exp_data  = mbyte;
              end else begin
                exp_err = 1'b1;
              end
              d = -1;
            end
          end
        end
      end
    end
  end

  logic [7:0] vq[$];
  int         nvalid = 0;
  int         nerr   = 0;

  initial begin : compare
    forever begin
      @(negedge clk);
      check("data_valid", 32'(bus.data_valid), 32'(exp_valid));
      check("frame_err",  32'(bus.frame_err),  32'(exp_err));
      check("data_out",   32'(bus.data_out),   32'(exp_data));
      if (bus.data_valid) begin
        nvalid++;
        vq.push_back(bus.data_out);
      end
      if (bus.frame_err) nerr++;
    end
  end

  task automatic slots(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.Rx        = v;
      bus.baud_tick = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.baud_tick = 1'b1;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    bus.baud_tick = 1'b0;
    arst_n        = 1'b0;
    @(negedge clk);
    check("rst_data_out", 32'(bus.data_out),   32'h0);
    check("rst_valid",    32'(bus.data_valid), 32'h0);
    check("rst_ferr",     32'(bus.frame_err),  32'h0);
    @(posedge clk); #1;
    arst_n = 1'b1;
  endtask

  // mode: 0 normal, 1 drop en in bit 7, 2 reset in bit 7, 3 high glitch at count 7 of bit 3
  task automatic frame(input logic [7:0] b, input logic stop, input int mode);
    slots(1'b0, OS);
    for (int k = 0; k < DB; k++) begin
      if (mode == 3 && k == 3) begin
        slots(b[7-k], 8);
        slots(~b[7-k], 1);
        slots(b[7-k], 7);
      end else if ((mode == 1 || mode == 2) && k == 7) begin
        slots(b[7-k], 5);
        if (mode == 1) begin
          @(posedge clk); #1;
          bus.baud_tick = 1'b0;
          bus.en        = 1'b0;
          @(posedge clk); #1;
          bus.en = 1'b1;
        end else begin
          pulse_reset();
        end
        slots(b[7-k], OS - 5);
      end else begin
        slots(b[7-k], OS);
      end
    end
    slots(stop, OS);
  endtask

  initial begin : stim
    int v0;
    int e0;
    bus.en        = 1'b1;
    bus.baud_tick = 1'b0;
    bus.Rx        = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_data_out", 32'(bus.data_out),   32'h0);
    check("reset_valid",    32'(bus.data_valid), 32'h0);
    check("reset_ferr",     32'(bus.frame_err),  32'h0);
    #1 arst_n = 1'b1;
    slots(1'b1, 4);

    frame(8'hA5, 1'b1, 0);
    slots(1'b1, 2);
    check("a5_count", 32'(nvalid), 32'd1);
    check("a5_data",  32'(bus.data_out), 32'hA5);
    check("a5_ferr",  32'(nerr), 32'd0);

    pulse_reset();
    v0 = nvalid;
    frame(8'h3C, 1'b0, 0);
    slots(1'b1, 12);
    check("3c_ferr",  32'(nerr), 32'd1);
    check("3c_valid", 32'(nvalid - v0), 32'd0);
    check("3c_data",  32'(bus.data_out), 32'h00);

    v0 = nvalid;
    e0 = nerr;
    slots(1'b0, 4);
    slots(1'b1, 12);
    check("false_start_pulses", 32'((nvalid - v0) + (nerr - e0)), 32'd0);
    frame(8'h81, 1'b1, 0);
    slots(1'b1, 2);
    check("81_data", 32'(bus.data_out), 32'h81);

    v0 = nvalid;
    frame(8'h00, 1'b1, 0);
    frame(8'hFF, 1'b1, 0);
    slots(1'b1, 2);
    check("b2b_count", 32'(nvalid - v0), 32'd2);
    if (vq.size() >= 2) begin
      check("b2b_first",  32'(vq[vq.size()-2]), 32'h00);
      check("b2b_second", 32'(vq[vq.size()-1]), 32'hFF);
    end else begin
      check("b2b_queue", 32'(vq.size()), 32'd2);
    end

    v0 = nvalid;
    e0 = nerr;
    frame(8'h55, 1'b1, 1);
    slots(1'b1, 4);
    check("en_drop_pulses", 32'((nvalid - v0) + (nerr - e0)), 32'd0);
    frame(8'h96, 1'b1, 0);
    slots(1'b1, 2);
    check("96_after_en", 32'(bus.data_out), 32'h96);

    v0 = nvalid;
    frame(8'h55, 1'b1, 2);
    slots(1'b1, 4);
    check("rst_frame_pulses", 32'(nvalid - v0), 32'd0);
    check("rst_frame_data",   32'(bus.data_out), 32'h00);
    frame(8'h96, 1'b1, 0);
    slots(1'b1, 2);
    check("96_after_rst", 32'(bus.data_out), 32'h96);

    v0 = nvalid;
    frame(8'h00, 1'b1, 3);
    slots(1'b1, 2);
    check("glitch_count", 32'(nvalid - v0), 32'd1);
    check("glitch_data",  32'(bus.data_out), 32'(GLITCH_EXP));

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: the far end of the team's 16x-oversampled transmitter link. Recovers 8-bit frames (1 start, 8 data MSB-first, 1 stop, no parity) from the serial line using the shared `baud_tick` oversampling strobe. Presents each byte on a parallel output with a one-cycle valid pulse, and flags framing errors. Sits between the pad-side serial input and the byte-consuming logic.

## Interface
- `OVERSAMPLE`, 16: baud_tick pulses per bit; must be a power of two, ≥8.
- `DATA_BITS`, 8: data bits per frame.
- `clk` input 1: single clock; all logic on rising edge.
- `arst_n` input 1: reset, asynchronous, active-low.
- `en` input 1: receiver enable; low forces IDLE.
- `baud_tick` input 1: one-`clk`-wide strobe at OVERSAMPLE × baud rate.
- `Rx` input 1: asynchronous serial line, idle high.
- `data_out` output DATA_BITS: last correctly framed byte.
- `data_valid` output 1: one-`clk` pulse when `data_out` updates.
- `frame_err` output 1: one-`clk` pulse when the stop bit samples low.

## Operation
- `Rx` passes through a 2-flop synchronizer (reset value 1). All decisions use the synchronized value `rx_s`.
- States:
  - IDLE: counters held at 0. On a `baud_tick` with `rx_s`=0, go to START with tick counter=0.
  - START: at the sample point, if the sampled value is 1 (false start), return to IDLE with no output. Otherwise continue. On the tick counter wrap (OVERSAMPLE-1 → 0), go to DATA with bit counter=0.
  - DATA: at each bit's sample point, `shift <= {shift[DATA_BITS-2:0], sample}` (MSB received first). On wrap after bit DATA_BITS-1, go to STOP.
  - STOP: at the sample point:
    - sample=1: `data_out <= shift` and pulse `data_valid`.
    - sample=0: pulse `frame_err`; `data_out` unchanged.
    - Either way, return to IDLE immediately (half-bit early), so back-to-back frames are accepted.
- The tick counter advances only on `baud_tick`. The bit counter advances only on tick wrap in DATA.
- `en` low: on the next edge, go to IDLE and clear the counters and shift register. No pulses are emitted. `data_out` is retained.
- `data_valid` and `frame_err` are never high together.

## Timing
- Reset values: `data_out`=0, `data_valid`=0, `frame_err`=0, state=IDLE, synchronizer=1.
- Input latency: `Rx` → `rx_s` is 2 `clk` cycles. `baud_tick` pulses must be spaced ≥3 `clk` cycles apart.
- Sample point: the `baud_tick` with tick counter = OVERSAMPLE/2−1 (count 7).
- Output latency: `data_valid` / `frame_err` is registered high in the `clk` cycle after the edge that processes the stop-bit sample tick, for exactly one cycle.
- Frame length seen by the receiver: start detection to result is 9×OVERSAMPLE + OVERSAMPLE/2 ticks (152 for 16x), plus the pipeline cycles.
- Reset mid-frame: immediate return to reset values. A partially received byte is discarded.
- A falling edge during STOP, after the sample point, cannot occur: the receiver is already back in IDLE and treats it as a new start.

## Configuration
- `UART_RX_MAJORITY_EN` defined:
  - Each bit decision (start confirm, data, stop) is the 2-of-3 majority of `rx_s` at tick counts OVERSAMPLE/2−2, −1, and 0 (6, 7, 8).
  - The decision takes effect at count 8. All output pulses shift one `baud_tick` later.
- Not defined: single sample at count 7. No extra sample registers are synthesized.

## Test plan
- Send 0xA5 (line: 0, 1,0,1,0,0,1,0,1, 1), 16 ticks/bit -> `data_out`=0xA5, one `data_valid` pulse, `frame_err` never high.
- Send 0x3C with the stop bit driven 0 -> one `frame_err` pulse, no `data_valid`, `data_out` keeps the prior value (0 after reset).
- Hold `Rx` low for 4 ticks, then high -> false start, return to IDLE, no pulses. A following 0x81 frame is received correctly.
- Send 0x00 then 0xFF back-to-back; the second start bit begins right after the first stop bit -> two `data_valid` pulses with values 0x00 and 0xFF, in order.
- Drop `en` for 1 cycle mid-DATA of frame 0x55 -> no pulse for that frame. Assert `arst_n`=0 mid-frame -> all outputs 0. Both cases: the next full frame 0x96 is received.
- A 1-tick high glitch at count 7 of bit 3 in 0x00 -> without the macro, `data_out`=0x10; with `UART_RX_MAJORITY_EN`, `data_out`=0x00.
